// File: rtl/rec2pol_sched.sv
// Round-robin scheduler sharing one rectangular-to-polar CORDIC engine between NREQ requesters.
// Grant is combinational in IDLE; the result is held in DONE until res_ready takes it.
module rec2pol_sched #(
    parameter int NREQ  = 4,
    parameter int TAGW  = 2,
    parameter int NITER = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_x,
    input  logic [32*NREQ-1:0]   req_y,
    output logic [NREQ-1:0]      req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [TAGW-1:0]      res_tag,
    output logic [31:0]          res_mod,
    output logic [31:0]          res_angle,
    output logic                 busy,
    output logic                 cordic_enable,
    output logic                 cordic_start,
    output logic [31:0]          cordic_x,
    output logic [31:0]          cordic_y,
    input  logic [31:0]          cordic_mod,
    input  logic [31:0]          cordic_angle
);
    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

    state_t          state, state_nxt;
    logic [TAGW-1:0] ptr, ptr_nxt;
    logic [5:0]      iter_cnt, iter_cnt_nxt;
    logic [31:0]     x_lat, x_lat_nxt;
    logic [31:0]     y_lat, y_lat_nxt;
    logic [TAGW-1:0] tag_lat, tag_lat_nxt;
    logic [31:0]     x_arr [NREQ];
    logic [31:0]     y_arr [NREQ];
    logic            grant_any;
    logic [TAGW-1:0] grant_idx;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign x_arr[i] = req_x[32*i +: 32];
        assign y_arr[i] = req_y[32*i +: 32];
    end

    // Walk the search order backwards so the requester nearest the pointer wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[TAGW'((int'(ptr) + k) % NREQ)]) begin
                grant_any = 1'b1;
                grant_idx = TAGW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        iter_cnt_nxt  = iter_cnt;
        x_lat_nxt     = x_lat;
        y_lat_nxt     = y_lat;
        tag_lat_nxt   = tag_lat;
        req_ready     = '0;
        res_valid     = 1'b0;
        cordic_enable = 1'b0;
        cordic_start  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any && !reset) begin
                    req_ready[grant_idx] = 1'b1;
                    x_lat_nxt            = x_arr[grant_idx];
                    y_lat_nxt            = y_arr[grant_idx];
                    tag_lat_nxt          = grant_idx;
                    ptr_nxt              = TAGW'((int'(grant_idx) + 1) % NREQ);
                    state_nxt            = LOAD;
                end
            end
            LOAD: begin
                cordic_start  = 1'b1;
                cordic_enable = 1'b1;
                iter_cnt_nxt  = '0;
                state_nxt     = ITER;
            end
            ITER: begin
                cordic_enable = 1'b1;
                iter_cnt_nxt  = iter_cnt + 6'd1;
                if (iter_cnt == 6'(NITER - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Engine stays disabled here so its outputs hold under backpressure.
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            iter_cnt <= '0;
            x_lat    <= '0;
            y_lat    <= '0;
            tag_lat  <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            iter_cnt <= iter_cnt_nxt;
            x_lat    <= x_lat_nxt;
            y_lat    <= y_lat_nxt;
            tag_lat  <= tag_lat_nxt;
        end
    end

    assign busy      = (state != IDLE);
    assign cordic_x  = x_lat;
    assign cordic_y  = y_lat;
    assign res_tag   = tag_lat;
    assign res_mod   = cordic_mod;
    assign res_angle = cordic_angle;
endmodule

// File: tb/tb_rec2pol_sched.sv
// Bench for rec2pol_sched with a behavioural CORDIC engine and a round-robin reference model.
`timescale 1ns/1ps
module tb_rec2pol_sched;
    localparam int NREQ  = 4;
    localparam int TAGW  = 2;
    localparam int NITER = 32;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [32*NREQ-1:0]  req_x = '0;
    logic [32*NREQ-1:0]  req_y = '0;
    logic [NREQ-1:0]     req_ready;
    logic                res_valid;
    logic                res_ready = 1'b0;
    logic [TAGW-1:0]     res_tag;
    logic [31:0]         res_mod, res_angle;
    logic                busy, cordic_enable, cordic_start;
    logic [31:0]         cordic_x, cordic_y;
    logic [31:0]         eng_mod, eng_ang;

    int total = 0;
    int bad   = 0;
    int model_ptr = 0;
    int cyc = 0;
    int en_cnt = 0;
    int st_cnt = 0;
    logic [31:0] opx [NREQ];
    logic [31:0] opy [NREQ];

    rec2pol_sched #(.NREQ(NREQ), .TAGW(TAGW), .NITER(NITER)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
        .res_mod(res_mod), .res_angle(res_angle), .busy(busy),
        .cordic_enable(cordic_enable), .cordic_start(cordic_start),
        .cordic_x(cordic_x), .cordic_y(cordic_y),
        .cordic_mod(eng_mod), .cordic_angle(eng_ang)
    );

    always #5 clock = ~clock;

    function automatic int ref_mod(input logic [31:0] x, input logic [31:0] y);
        real xr, yr;
        xr = $itor($signed(x)) / 65536.0;
        yr = $itor($signed(y)) / 65536.0;
        return $rtoi($sqrt(xr * xr + yr * yr) * 65536.0 + 0.5);
    endfunction

    function automatic int ref_ang(input logic [31:0] x, input logic [31:0] y);
        real a;
        a = $atan2($itor($signed(y)), $itor($signed(x))) * 180.0 / 3.14159265358979 * 16777216.0;
        return (a < 0.0) ? -$rtoi(-a + 0.5) : $rtoi(a + 0.5);
    endfunction

    function automatic longint adiff(input logic [31:0] a, input logic [31:0] b);
        longint d;
        d = longint'($signed(a)) - longint'($signed(b));
        return (d < 0) ? -d : d;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        return (g < 0) ? '0 : (NREQ'(1) << g);
    endfunction

    // Engine model: result valid only after exactly NITER enabled cycles following start.
    int eng_cnt = 0;
    logic [31:0] eng_x, eng_y;
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (cordic_enable) begin
            if (cordic_start) begin
                eng_x   <= cordic_x;
                eng_y   <= cordic_y;
                eng_cnt <= 0;
                eng_mod <= 32'hDEAD0000;
                eng_ang <= 32'hDEAD0000;
            end else begin
                eng_cnt <= eng_cnt + 1;
                if (eng_cnt + 1 == NITER) begin
                    eng_mod <= 32'(ref_mod(eng_x, eng_y));
                    eng_ang <= 32'(ref_ang(eng_x, eng_y));
                end else begin
                    eng_mod <= 32'(eng_cnt);
                    eng_ang <= ~32'(eng_cnt);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (cordic_enable === 1'b1) en_cnt <= en_cnt + 1;
        if (cordic_start === 1'b1) st_cnt <= st_cnt + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_x[32*i +: 32] = opx[i];
            req_y[32*i +: 32] = opy[i];
        end
    endtask

    task automatic issue(input int idx, input logic [31:0] x, input logic [31:0] y);
        opx[idx] = x;
        opy[idx] = y;
        drive_ops();
        req_valid = onehot(idx);
        #1;
    endtask

    task automatic wait_res(input int limit, output int n);
        n = 0;
        while (res_valid !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int g;
        reset = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        repeat (3) tick();
        total++;
        if ({req_ready, res_valid, busy, cordic_enable, cordic_start, res_tag} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=0", {req_ready, res_valid, busy, cordic_enable, cordic_start, res_tag});
        end
        total++;
        if ({cordic_x, cordic_y} !== 64'd0) begin
            bad++;
            $display("FAIL reset_xy got=%h exp=0", {cordic_x, cordic_y});
        end
        reset = 1'b0;
        model_ptr = 0;
    endtask

    task automatic test_single();
        int n;
        res_ready = 1'b1;
        issue(0, 32'h0001_0000, 32'h0);
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
        model_ptr = 1;
        tick();
        req_valid = '0;
        #1;
        total++;
        if (cordic_start !== 1'b1 || cordic_x !== 32'h0001_0000 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_load start=%b x=%h busy=%b exp=1/00010000/1", cordic_start, cordic_x, busy);
        end
        wait_res(100, n);
        total++;
        if (n !== NITER + 1) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", n + 1, NITER + 2); end
        total++;
        if (res_tag !== 2'd0) begin bad++; $display("FAIL single_tag got=%0d exp=0", res_tag); end
        total++;
        if (adiff(res_mod, 32'h0001_0000) > 64) begin bad++; $display("FAIL single_mod got=%h exp=00010000", res_mod); end
        total++;
        if (adiff(res_angle, 32'h0) > 256) begin bad++; $display("FAIL single_angle got=%h exp=00000000", res_angle); end
        tick();
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_release res_valid=%b busy=%b exp=0/0", res_valid, busy);
        end
    endtask

    task automatic test_diag45();
        int n, en0, st0;
        en0 = en_cnt;
        st0 = st_cnt;
        res_ready = 1'b1;
        issue(2, 32'h0001_0000, 32'h0001_0000);
        total++;
        if (req_ready !== onehot(rr_pick(4'b0100, model_ptr))) begin
            bad++; $display("FAIL diag_grant got=%b exp=0100", req_ready);
        end
        model_ptr = 3;
        tick();
        req_valid = '0;
        wait_res(100, n);
        total++;
        if (n >= 100) begin bad++; $display("FAIL diag_timeout got=%0d exp<100", n); end
        total++;
        if (res_tag !== 2'd2) begin bad++; $display("FAIL diag_tag got=%0d exp=2", res_tag); end
        total++;
        if (adiff(res_mod, 32'h0001_6A0A) > 64) begin bad++; $display("FAIL diag_mod got=%h exp=00016a0a", res_mod); end
        total++;
        if (adiff(res_angle, 32'h2D00_0000) > 256) begin bad++; $display("FAIL diag_angle got=%h exp=2d000000", res_angle); end
        tick();
        total++;
        if (st_cnt - st0 !== 1) begin bad++; $display("FAIL diag_start_cycles got=%0d exp=1", st_cnt - st0); end
        total++;
        if (en_cnt - en0 !== NITER + 1) begin bad++; $display("FAIL diag_enable_cycles got=%0d exp=%0d", en_cnt - en0, NITER + 1); end
    endtask

    task automatic test_round_robin();
        int n, g, last;
        last = 0;
        res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            opx[i] = 32'h0001_0000 * (i + 1);
            opy[i] = 32'h0000_8000 * (i + 1) + 32'h100;
        end
        drive_ops();
        req_valid = '1;
        #1;
        for (int j = 0; j <= NREQ; j++) begin
            n = 0;
            while (req_ready === '0 && n < 100) begin tick(); n++; end
            g = rr_pick(req_valid, model_ptr);
            total++;
            if (req_ready !== onehot(g)) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", j, req_ready, onehot(g)); end
            model_ptr = (g + 1) % NREQ;
            if (j > 0) begin
                total++;
                if (cyc - last !== NITER + 3) begin bad++; $display("FAIL rr_period got=%0d exp=%0d", cyc - last, NITER + 3); end
            end
            last = cyc;
            wait_res(100, n);
            total++;
            if (res_tag !== TAGW'(g) || adiff(res_mod, 32'(ref_mod(opx[g], opy[g]))) > 2) begin
                bad++;
                $display("FAIL rr_result%0d tag=%0d mod=%h exp tag=%0d mod=%h", j, res_tag, res_mod, g, ref_mod(opx[g], opy[g]));
            end
            tick();
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        int n;
        logic [31:0] s_mod, s_ang;
        logic [TAGW-1:0] s_tag;
        res_ready = 1'b0;
        issue(1, 32'h0003_0000, 32'hFFFE_0000);
        total++;
        if (req_ready !== onehot(rr_pick(4'b0010, model_ptr))) begin bad++; $display("FAIL bp_grant got=%b exp=0010", req_ready); end
        model_ptr = 2;
        tick();
        req_valid = '1;
        wait_res(100, n);
        s_mod = res_mod;
        s_ang = res_angle;
        s_tag = res_tag;
        total++;
        if (s_tag !== 2'd1 || s_mod !== 32'(ref_mod(opx[1], opy[1])) || s_ang !== 32'(ref_ang(opx[1], opy[1]))) begin
            bad++;
            $display("FAIL bp_result tag=%0d mod=%h ang=%h exp 1/%h/%h", s_tag, s_mod, s_ang, ref_mod(opx[1], opy[1]), ref_ang(opx[1], opy[1]));
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if (res_valid !== 1'b1 || res_mod !== s_mod || res_angle !== s_ang || res_tag !== s_tag) begin
                bad++;
                $display("FAIL bp_hold%0d valid=%b mod=%h ang=%h tag=%0d exp 1/%h/%h/%0d", c, res_valid, res_mod, res_angle, res_tag, s_mod, s_ang, s_tag);
            end
            total++;
            if (req_ready !== '0) begin bad++; $display("FAIL bp_no_grant%0d got=%b exp=0000", c, req_ready); end
        end
        res_ready = 1'b1;
        req_valid = '0;
        tick();
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_release valid=%b busy=%b exp=0/0", res_valid, busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        res_ready = 1'b1;
        issue(1, 32'h0002_0000, 32'h0001_0000);
        model_ptr = 2;
        tick();
        req_valid = '0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        total++;
        if ({req_ready, res_valid, busy, cordic_enable, cordic_start, res_tag} !== '0 || {cordic_x, cordic_y} !== 64'd0) begin
            bad++;
            $display("FAIL midreset_outputs ctrl=%b x=%h y=%h exp=0", {req_ready, res_valid, busy, cordic_enable, cordic_start, res_tag}, cordic_x, cordic_y);
        end
        reset = 1'b0;
        model_ptr = 0;
        opx[0] = 32'h0000_8000;
        opy[0] = 32'h0000_8000;
        opx[3] = 32'h0004_0000;
        opy[3] = 32'h0;
        drive_ops();
        req_valid = 4'b1001;
        #1;
        total++;
        if (req_ready !== onehot(rr_pick(4'b1001, model_ptr))) begin bad++; $display("FAIL midreset_ptr got=%b exp=0001", req_ready); end
        model_ptr = 1;
        tick();
        req_valid = '0;
        wait_res(100, n);
        total++;
        if (n >= 100 || res_tag !== 2'd0) begin bad++; $display("FAIL midreset_job tag=%0d wait=%0d exp tag=0", res_tag, n); end
        tick();
    endtask

    task automatic test_neg90();
        int n;
        res_ready = 1'b1;
        issue(3, 32'h0, 32'hFFFF_0000);
        total++;
        if (req_ready !== onehot(rr_pick(4'b1000, model_ptr))) begin bad++; $display("FAIL neg90_grant got=%b exp=1000", req_ready); end
        model_ptr = 0;
        tick();
        req_valid = '0;
        wait_res(100, n);
        total++;
        if (res_tag !== 2'd3) begin bad++; $display("FAIL neg90_tag got=%0d exp=3", res_tag); end
        total++;
        if (adiff(res_angle, 32'hA600_0000) > 256) begin bad++; $display("FAIL neg90_angle got=%h exp=a6000000", res_angle); end
        total++;
        if (adiff(res_mod, 32'h0001_0000) > 64) begin bad++; $display("FAIL neg90_mod got=%h exp=00010000", res_mod); end
        tick();
    endtask

    task automatic test_random();
        int g, c;
        bit done;
        logic [31:0] ex_mod, ex_ang;
        for (int j = 0; j < 30; j++) begin
            g = -1;
            c = 0;
            while (g < 0 && c < 50) begin
                for (int i = 0; i < NREQ; i++) begin
                    opx[i] = 32'($urandom_range(1, 32'h007F_FFFF));
                    opy[i] = 32'($urandom_range(0, 32'h00FF_FFFE)) - 32'h007F_FFFF;
                end
                drive_ops();
                req_valid = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
                res_ready = 1'($urandom);
                #1;
                g = rr_pick(req_valid, model_ptr);
                total++;
                if (req_ready !== onehot(g)) begin bad++; $display("FAIL rand_grant%0d got=%b exp=%b", j, req_ready, onehot(g)); end
                tick();
                c++;
            end
            total++;
            if (g < 0) begin bad++; $display("FAIL rand_no_request%0d got=none exp=grant", j); end
            else begin
                model_ptr = (g + 1) % NREQ;
                ex_mod = 32'(ref_mod(opx[g], opy[g]));
                ex_ang = 32'(ref_ang(opx[g], opy[g]));
            end
            done = 1'b0;
            for (int k = 0; k < 200 && !done && g >= 0; k++) begin
                req_valid = NREQ'($urandom);
                res_ready = 1'($urandom);
                #1;
                total++;
                if (req_ready !== '0) begin bad++; $display("FAIL rand_busy_grant%0d got=%b exp=0000", j, req_ready); end
                if (res_valid === 1'b1 && res_ready) begin
                    total++;
                    if (res_tag !== TAGW'(g) || res_mod !== ex_mod || res_angle !== ex_ang) begin
                        bad++;
                        $display("FAIL rand_result%0d tag=%0d mod=%h ang=%h exp %0d/%h/%h", j, res_tag, res_mod, res_angle, g, ex_mod, ex_ang);
                    end
                    done = 1'b1;
                end
                tick();
            end
            if (g >= 0) begin
                total++;
                if (!done) begin bad++; $display("FAIL rand_timeout%0d got=no_result exp=result", j); end
            end
        end
        req_valid = '0;
        res_ready = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            opx[i] = '0;
            opy[i] = '0;
        end
        test_reset();
        test_single();
        test_diag45();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_neg90();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/rec2pol_sched.md
# rec2pol_sched

Round-robin scheduler that shares one rectangular-to-polar CORDIC engine between NREQ requesters, e.g. the per-hydrophone-pair phase channels of the USBL front end. It accepts (x, y) jobs over valid/ready handshakes and drives the engine's start/enable sequencing for a fixed iteration count. It returns the engine's modulus/angle with a requester tag over a valid/ready result port. It sits between the channel front ends and the single engine instance, which has enable, start, x, y inputs and mod, angle outputs.

## Interface
- NREQ, 4: number of requesters (2..8).
- TAGW, 2: tag width, must equal ceil(log2(NREQ)).
- NITER, 32: iteration cycles the engine runs after its start cycle (1..63).
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NREQ  bit i: requester i has a job.
- req_x  in  32*NREQ  X of requester i at [32i+31:32i], 16Q16 signed.
- req_y  in  32*NREQ  Y of requester i, same packing, 16Q16 signed.
- req_ready  out  NREQ  one-hot grant/accept, at most one bit high.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_tag  out  TAGW  index of the requester that owns the result.
- res_mod  out  32  modulus, 16Q16.
- res_angle  out  32  angle in degrees, 8Q24 signed.
- busy  out  1  high in every state except IDLE.
- cordic_enable  out  1  engine enable.
- cordic_start  out  1  engine start.
- cordic_x, cordic_y  out  32 each  engine operands.
- cordic_mod, cordic_angle  in  32 each  engine results.

## Operation
- Reset values: state=IDLE, rr pointer=0, iteration counter=0, latched x/y/tag=0, req_ready=0, res_valid=0, busy=0, cordic_enable=0, cordic_start=0, cordic_x/y=0.
- FSM states: IDLE, LOAD, ITER, DONE.
- IDLE: grant goes to the first requester with req_valid set, searching pointer, pointer+1, …, wrapping mod NREQ. The grant is combinational. req_ready[g]=1 in that cycle only. At the clock edge, latch req_x/req_y slice g and tag g, set pointer=(g+1) mod NREQ, go to LOAD. If no request is valid, stay in IDLE with the pointer unchanged.
- LOAD (1 cycle): cordic_start=1, cordic_enable=1, cordic_x/y driven from the latches. Clear the iteration counter. Go to ITER.
- ITER: cordic_enable=1, cordic_start=0. The counter increments each cycle. After NITER cycles (counter == NITER-1 at the edge), go to DONE.
- DONE: cordic_enable=0, so the engine holds its registers. res_valid=1. res_mod=cordic_mod, res_angle=cordic_angle, res_tag from the latch. All three are stable while res_valid is high. When res_valid and res_ready are both high at an edge, go to IDLE. Otherwise stay in DONE indefinitely (backpressure).
- cordic_x/y hold the latched values in all states. They are only sampled by the engine in LOAD.
- A requester may drop req_valid before it is granted. Only the state at the grant cycle matters. No job is ever lost or duplicated.
- No arithmetic is done on data; widths pass through unchanged.

## Timing
- Acceptance cycle A (IDLE, req_ready high). LOAD at A+1. ITER from A+2 to A+NITER+1. res_valid first high at A+NITER+2.
- Minimum job period is NITER+3 cycles: the handshake in DONE at cycle D leads to IDLE at D+1, which may accept at D+1.
- req_ready is never high outside IDLE. res_valid is never high outside DONE.
- Simultaneous requests are served in round-robin order. The maximum wait for a continuously valid requester is NREQ-1 jobs.
- Reset asserted in any state (including mid-ITER or DONE) returns all registers to reset values on the next edge. The in-flight job is discarded, and res_valid is 0 in the cycle after reset.
- res_ready high while in IDLE/LOAD/ITER is ignored.

## Test plan
- Single job from requester 0 with x=0x00010000, y=0, res_ready=1: req_ready[0] at cycle A, res_valid at A+34, res_tag=0, res_mod=0x00010000 ±0x40, res_angle=0 ±0x100.
- Requester 2 with x=y=0x00010000: res_tag=2, res_mod=0x00016A0A ±0x40, res_angle=0x2D000000 (45°) ±0x100. cordic_start is high exactly one cycle, and cordic_enable is high for exactly 33 cycles.
- All four req_valid held high with distinct operands: grants in order 0,1,2,3,0. Each result tag matches its operands. Job period is 35 cycles.
- Backpressure: res_ready=0 for 10 cycles in DONE. res_valid, res_mod, res_angle and res_tag stay constant, no req_ready is raised, and the job completes when res_ready=1.
- Reset mid-ITER (cycle A+10): all outputs are 0 the next cycle. A new job from requester 3 after reset is granted first only if requesters 0..2 are idle, since the pointer is back at 0.
- x=0, y=0xFFFF0000 (-1.0): res_angle=0xA6000000 (-90°) ±0x100, res_mod=0x00010000 ±0x40.
